vram_arbiter: RTL and testbench

- Shares one single-port synchronous video/system RAM between the CPU bus and the VPU scan-out fetcher.
- The RAM has a fixed 1-cycle read latency.
- The VPU gets priority, since display timing is real-time. A starvation guard guarantees the CPU a slot after a bounded run of VPU grants.
- The CPU is stalled through `cpu_hold`, which gates the CPU clock at top level.

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 53 +++++
 rtl/vram_arbiter_arb_prio.sv | 79 +++++++
 rtl/vram_arbiter.sv | 86 ++++++++
 tb/tb_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared definitions for the VRAM arbiter slice: the grant-state encoding used
// by the priority logic and the datapath, plus default bus widths.
// ----------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    // Who owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_VPU  = 2'b10
    } gnt_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// ----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the CPU bus, the VPU fetch port and the single-port RAM port.
//   slave  : arbiter view (takes requests and RAM read data, drives grants,
//            stalls, read returns and the RAM strobes)
//   master : requester/RAM view (the mirror image of slave)
// ----------------------------------------------------------------------------
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) ();

    logic          cpu_req;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_hold;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          vpu_req;
    logic [AW-1:0] vpu_addr;
    logic          vpu_ack;
    logic [DW-1:0] vpu_rdata;
    logic          vpu_rvalid;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  vpu_req, vpu_addr,
        input  mem_rdata,
        output cpu_hold, cpu_rdata, cpu_rvalid,
        output vpu_ack, vpu_rdata, vpu_rvalid,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output vpu_req, vpu_addr,
        output mem_rdata,
        input  cpu_hold, cpu_rdata, cpu_rvalid,
        input  vpu_ack, vpu_rdata, vpu_rvalid,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vram_arbiter_arb_prio.sv
// ----------------------------------------------------------------------------
// vram_arbiter_arb_prio
// Grant decision and starvation guard. The VPU normally wins; once it has
// taken MAX_VPU_RUN grants in a row while the CPU was waiting, the CPU gets
// the next slot.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   cpu_req_i      CPU access presented
//   cpu_done_i     cycle after a CPU grant (the access is being retired)
//   vpu_req_i      VPU fetch wanted
//   gnt_o          registered grant state for the current cycle
// ----------------------------------------------------------------------------
module vram_arbiter_arb_prio
    import vram_arbiter_pkg::*;
#(
    parameter int MAX_VPU_RUN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cpu_req_i,
    input  logic cpu_done_i,
    input  logic vpu_req_i,
    output gnt_e gnt_o
);

    // The run counter is only 4 bits wide, so the limit must fit in it.
    if (MAX_VPU_RUN < 1 || MAX_VPU_RUN > 15) begin : g_bad_max_run
        $error("vram_arbiter_arb_prio: MAX_VPU_RUN must be in 1..15");
    end

    localparam logic [3:0] RunMax = 4'(MAX_VPU_RUN);

    gnt_e       gnt_q, gnt_d;
    logic [3:0] run_q, run_d;
    logic       cpuElig;

    // A held CPU access must not be granted again while it is in its grant or
    // done cycle; it stays on the bus until the gated CPU clock advances.
    assign cpuElig = cpu_req_i && !cpu_done_i && (gnt_q != GNT_CPU);

    // Priority pick for the next cycle. A VPU grant always implies an ack, so
    // the VPU has a fresh address whenever it keeps requesting and may be
    // granted every cycle; only the starvation limit can pre-empt it.
    always_comb begin
        gnt_d = GNT_NONE;
        if (cpuElig && (run_q == RunMax)) begin
            gnt_d = GNT_CPU;
        end else if (vpu_req_i) begin
            gnt_d = GNT_VPU;
        end else if (cpuElig) begin
            gnt_d = GNT_CPU;
        end
    end

    // Count VPU wins that made a waiting CPU wait longer; anything else
    // (CPU served or no CPU waiting) restarts the count.
    always_comb begin
        run_d = run_q;
        if (!cpuElig || (gnt_d == GNT_CPU)) begin
            run_d = 4'd0;
        end else if (gnt_d == GNT_VPU && run_q != RunMax) begin
            run_d = run_q + 4'd1;
        end
    end

    // Grant and run state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q <= GNT_NONE;
            run_q <= 4'd0;
        end else begin
            gnt_q <= gnt_d;
            run_q <= run_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// CPU bus and the VPU scan-out fetcher. The CPU is stalled with cpu_hold,
// which gates its clock.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus (slave)    CPU request/stall/read-return, VPU fetch/ack/read-return,
//                  RAM strobes and read data
// ----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW          = VRAM_AW,
    parameter int DW          = VRAM_DW,
    parameter int MAX_VPU_RUN = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vram_arbiter_if.slave  bus
);

    gnt_e          gnt;
    logic          cpuDone_q;
    logic          cpuRvalid_q;
    logic          vpuRvalid_q;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;

    vram_arbiter_arb_prio #(
        .MAX_VPU_RUN (MAX_VPU_RUN)
    ) u_arb_prio (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cpu_req_i  (bus.cpu_req),
        .cpu_done_i (cpuDone_q),
        .vpu_req_i  (bus.vpu_req),
        .gnt_o      (gnt)
    );

    // RAM address/data steering; an idle port shows all zeros.
    always_comb begin
        memAddr  = '0;
        memWdata = '0;
        case (gnt)
            GNT_CPU: begin
                memAddr  = bus.cpu_addr;
                memWdata = bus.cpu_wdata;
            end
            GNT_VPU: begin
                memAddr  = bus.vpu_addr;
                memWdata = bus.cpu_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_cs    = (gnt != GNT_NONE);
    assign bus.mem_we    = (gnt == GNT_CPU) && !bus.cpu_rw;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.vpu_ack   = (gnt == GNT_VPU);

    // Track which requester owns the RAM output next cycle, and flag the CPU
    // done cycle. Reset drops any read that is still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpuDone_q   <= 1'b0;
            cpuRvalid_q <= 1'b0;
            vpuRvalid_q <= 1'b0;
        end else begin
            cpuDone_q   <= (gnt == GNT_CPU);
            cpuRvalid_q <= (gnt == GNT_CPU) && bus.cpu_rw;
            vpuRvalid_q <= (gnt == GNT_VPU);
        end
    end

    // The CPU clock only advances in the done cycle.
    assign bus.cpu_hold   = bus.cpu_req && !cpuDone_q;

    assign bus.cpu_rvalid = cpuRvalid_q;
    assign bus.vpu_rvalid = vpuRvalid_q;
    assign bus.cpu_rdata  = cpuRvalid_q ? bus.mem_rdata : '0;
    assign bus.vpu_rdata  = vpuRvalid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_arbiter
// Scoreboard bench for vram_arbiter. Stimulus pushes hand-computed grants and
// read data into queues; monitors pop and compare whenever the DUT strobes the
// RAM or returns read data. A second instance with MAX_VPU_RUN=1 checks the
// tight starvation limit.
// ----------------------------------------------------------------------------
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    typedef struct {
        gnt_e        kind;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } grant_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cpuop_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    vram_arbiter_if #(.AW(16), .DW(8)) bus  ();
    vram_arbiter_if #(.AW(16), .DW(8)) bus1 ();

    vram_arbiter #(.AW(16), .DW(8), .MAX_VPU_RUN(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    vram_arbiter #(.AW(16), .DW(8), .MAX_VPU_RUN(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    grant_t      grantQ[$];
    logic [7:0]  vpuQ[$];
    logic [7:0]  cpuQ[$];
    gnt_e        grant1Q[$];
    logic [15:0] addr1Q[$];
    cpuop_t      cpuOps[$];
    int          cpuGrantCycles[$];

    int          vpuLeft = 0;
    logic [15:0] vpuAddr = '0;
    logic        ackSeen, holdSeen, reqSeen;
    logic        holdAny;

    logic [7:0]  ram [logic [15:0]];
    logic [7:0]  memRd = '0;

    // Contents of locations never written by the bench.
    function automatic logic [7:0] presetData(input logic [15:0] a);
        if (a >= 16'h1000 && a <= 16'h1007) return 8'h30 + 8'(a - 16'h1000);
        if (a == 16'h0300) return 8'h5C;
        return 8'h00;
    endfunction

    // Synchronous single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            else memRd <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : presetData(bus.mem_addr);
        end
    end
    assign bus.mem_rdata  = memRd;
    assign bus1.mem_rdata = 8'h00;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic failNow(input string name, input logic [31:0] actual);
        checks++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
    endtask

    // Main-instance monitor: compare every RAM strobe and every read return
    // against the scoreboard queues.
    grant_t gMon;
    always @(negedge clk) begin
        if (bus.mem_cs) begin
            if (grantQ.size() == 0) begin
                failNow("unexpected grant addr", 32'(bus.mem_addr));
            end else begin
                gMon = grantQ.pop_front();
                checkOutput("grant kind", bus.vpu_ack ? 32'(GNT_VPU) : 32'(GNT_CPU), 32'(gMon.kind));
                checkOutput("grant addr", 32'(bus.mem_addr), 32'(gMon.addr));
                checkOutput("grant we", 32'(bus.mem_we), 32'(gMon.we));
                if (gMon.we) checkOutput("grant wdata", 32'(bus.mem_wdata), 32'(gMon.wdata));
                if (!bus.vpu_ack) begin
                    checkOutput("hold in cpu grant", 32'(bus.cpu_hold), 32'd1);
                    cpuGrantCycles.push_back(cycle);
                end
            end
        end
        if (bus.vpu_rvalid) begin
            if (vpuQ.size() == 0) failNow("unexpected vpu_rvalid", 32'(bus.vpu_rdata));
            else checkOutput("vpu_rdata", 32'(bus.vpu_rdata), 32'(vpuQ.pop_front()));
        end else begin
            checkOutput("vpu_rdata idle", 32'(bus.vpu_rdata), 32'd0);
        end
        if (bus.cpu_rvalid) begin
            checkOutput("hold in done cycle", 32'(bus.cpu_hold), 32'd0);
            if (cpuQ.size() == 0) failNow("unexpected cpu_rvalid", 32'(bus.cpu_rdata));
            else checkOutput("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpuQ.pop_front()));
        end else begin
            checkOutput("cpu_rdata idle", 32'(bus.cpu_rdata), 32'd0);
        end
    end

    // MAX_VPU_RUN=1 instance monitor: grant order and address only.
    always @(negedge clk) begin
        if (bus1.mem_cs && grant1Q.size() > 0) begin
            checkOutput("run1 grant kind", bus1.vpu_ack ? 32'(GNT_VPU) : 32'(GNT_CPU), 32'(grant1Q.pop_front()));
            checkOutput("run1 grant addr", 32'(bus1.mem_addr), 32'(addr1Q.pop_front()));
        end
    end

    // Drive the main bus from the VPU and CPU agent state.
    task automatic applyStimulus();
        bus.vpu_req  = (vpuLeft > 0);
        bus.vpu_addr = (vpuLeft > 0) ? vpuAddr : 16'h0000;
        if (cpuOps.size() > 0) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_rw    = cpuOps[0].rw;
            bus.cpu_addr  = cpuOps[0].addr;
            bus.cpu_wdata = cpuOps[0].wdata;
        end else begin
            bus.cpu_req   = 1'b0;
            bus.cpu_rw    = 1'b0;
            bus.cpu_addr  = 16'h0000;
            bus.cpu_wdata = 8'h00;
        end
    endtask

    // One clock: the VPU drops its request in the cycle of its final ack and
    // advances on each ack; the CPU advances only after its done cycle.
    task automatic tick();
        @(negedge clk);
        #1;
        ackSeen  = bus.vpu_ack;
        holdSeen = bus.cpu_hold;
        reqSeen  = bus.cpu_req;
        if (holdSeen) holdAny = 1'b1;
        if (ackSeen && vpuLeft == 1) bus.vpu_req = 1'b0;
        @(posedge clk);
        #1;
        if (ackSeen && vpuLeft > 0) begin
            vpuLeft--;
            vpuAddr++;
        end
        if (reqSeen && !holdSeen && cpuOps.size() > 0) void'(cpuOps.pop_front());
        applyStimulus();
    endtask

    task automatic waitDone(input string name, input int bound);
        int n = 0;
        while ((grantQ.size() > 0 || vpuQ.size() > 0 || cpuQ.size() > 0 ||
                vpuLeft > 0 || cpuOps.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) failNow({name, " timeout"}, 32'(n));
        repeat (3) tick();
    endtask

    task automatic pushGrant(input gnt_e k, input logic [15:0] a, input logic we, input logic [7:0] wd);
        grant_t g;
        g.kind = k; g.addr = a; g.we = we; g.wdata = wd;
        grantQ.push_back(g);
    endtask

    task automatic pushCpuOp(input logic rw, input logic [15:0] a, input logic [7:0] wd);
        cpuop_t op;
        op.rw = rw; op.addr = a; op.wdata = wd;
        cpuOps.push_back(op);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout at cycle %0d", cycle);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int reqCycle;
        gnt_e seq1 [10];

        applyStimulus();
        bus1.vpu_req = 1'b0; bus1.vpu_addr = '0;
        bus1.cpu_req = 1'b0; bus1.cpu_rw = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;

        // Reset: everything idle, cpu_hold still follows cpu_req.
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset mem_cs", 32'(bus.mem_cs), 32'd0);
        checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("reset vpu_ack", 32'(bus.vpu_ack), 32'd0);
        checkOutput("reset cpu_hold idle", 32'(bus.cpu_hold), 32'd0);
        bus.cpu_req = 1'b1;
        #1 checkOutput("reset cpu_hold follows req", 32'(bus.cpu_hold), 32'd1);
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        // VPU only: four back-to-back fetches, CPU never stalled.
        holdAny = 1'b0;
        vpuLeft = 4; vpuAddr = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            pushGrant(GNT_VPU, 16'h1000 + 16'(i), 1'b0, 8'h00);
            vpuQ.push_back(8'h30 + 8'(i));
        end
        applyStimulus();
        waitDone("vpu only", 40);
        checkOutput("vpu only cpu_hold", 32'(holdAny), 32'd0);

        // CPU only: write then read back, grants three cycles apart.
        cpuGrantCycles.delete();
        pushCpuOp(1'b0, 16'h0200, 8'hA5);
        pushCpuOp(1'b1, 16'h0200, 8'h00);
        pushGrant(GNT_CPU, 16'h0200, 1'b1, 8'hA5);
        pushGrant(GNT_CPU, 16'h0200, 1'b0, 8'h00);
        cpuQ.push_back(8'hA5);
        applyStimulus();
        waitDone("cpu only", 40);
        checkOutput("cpu grant count", 32'(cpuGrantCycles.size()), 32'd2);
        if (cpuGrantCycles.size() == 2)
            checkOutput("cpu access spacing", 32'(cpuGrantCycles[1] - cpuGrantCycles[0]), 32'd3);

        // Contention from a simultaneous start: 4 VPU, 1 CPU, then VPU resumes.
        cpuGrantCycles.delete();
        vpuLeft = 8; vpuAddr = 16'h1000;
        pushCpuOp(1'b1, 16'h0300, 8'h00);
        for (int i = 0; i < 4; i++) pushGrant(GNT_VPU, 16'h1000 + 16'(i), 1'b0, 8'h00);
        pushGrant(GNT_CPU, 16'h0300, 1'b0, 8'h00);
        for (int i = 4; i < 8; i++) pushGrant(GNT_VPU, 16'h1000 + 16'(i), 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) vpuQ.push_back(8'h30 + 8'(i));
        cpuQ.push_back(8'h5C);
        reqCycle = cycle;
        applyStimulus();
        waitDone("contention", 60);
        checkOutput("contention cpu grants", 32'(cpuGrantCycles.size()), 32'd1);
        if (cpuGrantCycles.size() == 1)
            checkOutput("contention cpu wait", 32'(cpuGrantCycles[0] - reqCycle), 32'd5);

        // Reset in the cycle after a VPU grant drops the pending read.
        vpuLeft = 1; vpuAddr = 16'h1005;
        pushGrant(GNT_VPU, 16'h1005, 1'b0, 8'h00);
        applyStimulus();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset vpu_rvalid", 32'(bus.vpu_rvalid), 32'd0);
        checkOutput("mid reset vpu_rdata", 32'(bus.vpu_rdata), 32'd0);
        checkOutput("mid reset mem_cs", 32'(bus.mem_cs), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("post reset mem_cs", 32'(bus.mem_cs), 32'd0);
        pushCpuOp(1'b1, 16'h0200, 8'h00);
        pushGrant(GNT_CPU, 16'h0200, 1'b0, 8'h00);
        cpuQ.push_back(8'hA5);
        applyStimulus();
        waitDone("after reset", 40);

        // MAX_VPU_RUN=1 under full contention; the CPU re-requests as soon
        // as each access retires.
        seq1 = '{GNT_VPU, GNT_CPU, GNT_VPU, GNT_VPU, GNT_VPU,
                 GNT_CPU, GNT_VPU, GNT_VPU, GNT_VPU, GNT_CPU};
        for (int i = 0; i < 10; i++) begin
            grant1Q.push_back(seq1[i]);
            addr1Q.push_back(seq1[i] == GNT_CPU ? 16'h0400 : 16'h2000);
        end
        bus1.vpu_req = 1'b1; bus1.vpu_addr = 16'h2000;
        bus1.cpu_req = 1'b1; bus1.cpu_rw = 1'b1; bus1.cpu_addr = 16'h0400;
        for (int n = 0; n < 30 && grant1Q.size() > 0; n++) tick();
        if (grant1Q.size() > 0) failNow("run1 timeout", 32'(grant1Q.size()));
        bus1.vpu_req = 1'b0; bus1.cpu_req = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
